// File: rtl/send_arbiter_if.sv
// Requester byte streams plus the framing ring and length-fifo write
// ports of send_arbiter, bundled with master/slave views.
interface send_arbiter_if #(
  parameter int NREQ     = 4,
  parameter int LEN_BITS = 6
);
  logic [NREQ-1:0]     req_valid;
  logic [8*NREQ-1:0]   req_data;
  logic [NREQ-1:0]     req_last;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ-1:0]     grant;
  logic [7:0]          send_ring_data;
  logic                send_ring_wr_en;
  logic                send_ring_full;
  logic [LEN_BITS-1:0] send_fifo_data;
  logic                send_fifo_wr_en;
  logic                send_fifo_full;
  logic                overflow;

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    output send_ring_full,
    output send_fifo_full,
    input  req_ready,
    input  grant,
    input  send_ring_data,
    input  send_ring_wr_en,
    input  send_fifo_data,
    input  send_fifo_wr_en,
    input  overflow
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    input  send_ring_full,
    input  send_fifo_full,
    output req_ready,
    output grant,
    output send_ring_data,
    output send_ring_wr_en,
    output send_fifo_data,
    output send_fifo_wr_en,
    output overflow
  );
endinterface

// File: rtl/send_arbiter.sv
// Round-robin arbiter muxing requester byte streams onto the framing
// send ring and posting one length word per message.
module send_arbiter #(
  parameter int NREQ     = 4,
  parameter int LEN_BITS = 6
) (
  input logic           clk,
  input logic           rst,
  send_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    COMMIT
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [IW-1:0]       gidx;
  logic [IW-1:0]       last_grant;
  logic [IW-1:0]       win;
  logic                found;
  logic [NREQ-1:0]     grant_q;
  logic [LEN_BITS-1:0] cnt;
  logic                trunc;
  logic                vld;
  logic                lst;
  logic                hs;
  logic                at_max;
  logic                wr;

  always_comb begin : rr
    int j;
    logic [IW-1:0] jj;
    win   = '0;
    found = 1'b0;
    j     = 0;
    jj    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j  = (int'(last_grant) + k) % NREQ;
      jj = IW'(j);
      if (!found && bus.req_valid[jj]) begin
        found = 1'b1;
        win   = jj;
      end
    end
  end

  assign vld    = bus.req_valid[gidx];
  assign lst    = bus.req_last[gidx];
  assign at_max = &cnt;
  assign hs     = (state == XFER) && vld
                  && !bus.send_ring_full;
  // At the length ceiling bytes are still accepted but not written.
  assign wr     = hs && !at_max;

  always_comb begin
    state_nx            = state;
    bus.req_ready       = '0;
    bus.grant           = grant_q;
    bus.send_ring_wr_en = wr;
    bus.send_ring_data  = 8'h00;
    bus.send_fifo_wr_en = 1'b0;
    bus.send_fifo_data  = cnt;
    bus.overflow        = 1'b0;
    unique case (state)
      IDLE: begin
        if (found && !bus.send_fifo_full)
          state_nx = XFER;
      end
      XFER: begin
        bus.req_ready[gidx] = !bus.send_ring_full;
        bus.send_ring_data  =
          bus.req_data[{gidx, 3'b000} +: 8];
        if (hs && lst)
          state_nx = COMMIT;
      end
      COMMIT: begin
        bus.send_fifo_wr_en = 1'b1;
        bus.overflow        = trunc;
        state_nx            = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant_q    <= '0;
      gidx       <= '0;
      last_grant <= IW'(NREQ - 1);
      cnt        <= '0;
      trunc      <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (state_nx == XFER) begin
            gidx    <= win;
            grant_q <= NREQ'(1) << win;
            cnt     <= '0;
            trunc   <= 1'b0;
          end
        end
        XFER: begin
          if (wr)
            cnt <= cnt + 1'b1;
          if (hs && at_max)
            trunc <= 1'b1;
        end
        COMMIT: begin
          last_grant <= gidx;
          grant_q    <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_send_arbiter.sv
// Scoreboard bench for send_arbiter: per-requester byte/length queues
// filled at stimulus time and drained as the DUT writes ring and fifo.
module tb_send_arbiter;
  localparam int NREQ = 4;
  localparam int LB   = 6;
  localparam int MAXL = 63;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  send_arbiter_if #(.NREQ(NREQ), .LEN_BITS(LB)) bus ();

  send_arbiter #(.NREQ(NREQ), .LEN_BITS(LB)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [8:0]      src_q    [NREQ][$];
  logic [7:0]      exp_ring [NREQ][$];
  int              exp_len  [NREQ][$];
  bit              exp_ovf  [NREQ][$];
  int              act_grant[$];
  logic [NREQ-1:0] fire;
  logic [NREQ-1:0] prev_grant;
  int              cur_g;
  int              errors;
  int              checks;
  int              n_ring;
  int              n_fifo;
  int              n_ovf;
  bit              ring_now;
  bit              fifo_now;

  task automatic monitor();
    logic [7:0] e;
    int el;
    bit eo;
    ring_now = bus.send_ring_wr_en;
    fifo_now = bus.send_fifo_wr_en;
    fire = bus.req_valid & bus.req_ready;
    if (rst) begin
      prev_grant = bus.grant;
      return;
    end
    if (bus.grant != '0) begin
      checks++;
      if (!$onehot(bus.grant)) begin
        errors++;
        $display("FAIL grant_onehot: got %b need one-hot", bus.grant);
      end
      for (int i = 0; i < NREQ; i++)
        if (bus.grant[i]) cur_g = i;
      if (prev_grant == '0) act_grant.push_back(cur_g);
    end
    prev_grant = bus.grant;
    if (bus.send_ring_full) begin
      checks++;
      if (bus.req_ready !== '0 || bus.send_ring_wr_en !== 1'b0) begin
        errors++;
        $display("FAIL ring_full_stall: ready=%b wr=%b need 0/0",
                 bus.req_ready, bus.send_ring_wr_en);
      end
    end
    if (bus.send_ring_wr_en) begin
      n_ring++;
      checks++;
      if (exp_ring[cur_g].size() == 0) begin
        errors++;
        $display("FAIL ring_extra: req %0d wrote %h, none expected",
                 cur_g, bus.send_ring_data);
      end else begin
        e = exp_ring[cur_g].pop_front();
        if (bus.send_ring_data !== e || !fire[cur_g]) begin
          errors++;
          $display("FAIL ring_data: req %0d got %h need %h (fire=%b)",
                   cur_g, bus.send_ring_data, e, fire);
        end
      end
    end
    if (bus.send_fifo_wr_en) begin
      n_fifo++;
      checks++;
      if (exp_len[cur_g].size() == 0) begin
        errors++;
        $display("FAIL fifo_extra: req %0d len %0d, none expected",
                 cur_g, bus.send_fifo_data);
      end else begin
        el = exp_len[cur_g].pop_front();
        eo = exp_ovf[cur_g].pop_front();
        if (bus.send_fifo_data !== LB'(el) || bus.overflow !== eo) begin
          errors++;
          $display("FAIL fifo_len: req %0d got len=%0d ovf=%b need %0d/%b",
                   cur_g, bus.send_fifo_data, bus.overflow, el, eo);
        end
      end
    end
    if (bus.overflow) begin
      n_ovf++;
      checks++;
      if (bus.send_fifo_wr_en !== 1'b1) begin
        errors++;
        $display("FAIL ovf_alone: overflow without fifo write");
      end
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      fire[i] = 1'b0;
      if (src_q[i].size() > 0) begin
        bus.req_valid[i]      = 1'b1;
        bus.req_data[8*i +: 8] = src_q[i][0][7:0];
        bus.req_last[i]       = src_q[i][0][8];
      end else begin
        bus.req_valid[i]      = 1'b0;
        bus.req_data[8*i +: 8] = 8'h00;
        bus.req_last[i]       = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic load_msg(input int i, input int n,
                          input int base, input int step);
    logic [7:0] b;
    for (int k = 0; k < n; k++) begin
      b = 8'(base + step * k);
      src_q[i].push_back({k == n - 1, b});
      if (k < MAXL) exp_ring[i].push_back(b);
    end
    exp_len[i].push_back(n < MAXL ? n : MAXL);
    exp_ovf[i].push_back(n > MAXL);
  endtask

  function automatic bit busy();
    for (int i = 0; i < NREQ; i++)
      if (src_q[i].size() > 0 || exp_ring[i].size() > 0
          || exp_len[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic flush();
    for (int i = 0; i < NREQ; i++) begin
      src_q[i].delete();
      exp_ring[i].delete();
      exp_len[i].delete();
      exp_ovf[i].delete();
    end
    act_grant.delete();
  endtask

  task automatic do_reset();
    flush();
    rst = 1'b1;
    drive();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int c = 0;
    while (busy() && c < budget) begin
      tick();
      c++;
    end
    checks++;
    if (busy()) begin
      errors++;
      $display("FAIL %s_timeout: still busy after %0d cycles", name, c);
    end
    tick();
    tick();
  endtask

  task automatic wait_ring(input string name, input int want,
                           input int budget);
    int c = 0;
    while (n_ring < want && c < budget) begin
      tick();
      c++;
    end
    checks++;
    if (n_ring < want) begin
      errors++;
      $display("FAIL %s_wait: ring writes %0d need %0d", name, n_ring, want);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    checks++;
    if (bus.grant !== '0) begin
      errors++;
      $display("FAIL rst_grant: got %b need 0", bus.grant);
    end
    checks++;
    if (bus.req_ready !== '0) begin
      errors++;
      $display("FAIL rst_ready: got %b need 0", bus.req_ready);
    end
    checks++;
    if (bus.send_ring_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_ring_wr: got %b need 0", bus.send_ring_wr_en);
    end
    checks++;
    if (bus.send_fifo_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_fifo_wr: got %b need 0", bus.send_fifo_wr_en);
    end
    checks++;
    if (bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL rst_ovf: got %b need 0", bus.overflow);
    end
  endtask

  task automatic test_single();
    int first = 0;
    int last = 0;
    int fat = 0;
    int r0;
    do_reset();
    r0 = n_ring;
    load_msg(1, 3, 8'h11, 8'h11);
    drive();
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (ring_now && first == 0) first = t;
      if (ring_now) last = t;
      if (fifo_now && fat == 0) fat = t;
    end
    checks++;
    if (first != 2 || last != 4 || n_ring - r0 != 3) begin
      errors++;
      $display("FAIL single_ring: first=%0d last=%0d n=%0d need 2/4/3",
               first, last, n_ring - r0);
    end
    checks++;
    if (fat != 5) begin
      errors++;
      $display("FAIL single_latency: fifo at cycle %0d need 5", fat);
    end
    checks++;
    if (act_grant.size() != 1 || act_grant[0] != 1) begin
      errors++;
      $display("FAIL single_grant: got %p need '{1}", act_grant);
    end
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    int f0;
    do_reset();
    f0 = n_fifo;
    load_msg(0, 2, 8'h00, 1);
    load_msg(1, 3, 8'h10, 1);
    load_msg(2, 1, 8'h20, 1);
    load_msg(3, 4, 8'h30, 1);
    load_msg(0, 2, 8'h40, 1);
    drive();
    drain("rr", 200);
    checks++;
    if (act_grant.size() != 5 || n_fifo - f0 != 5) begin
      errors++;
      $display("FAIL rr_count: grants=%0d fifo=%0d need 5/5",
               act_grant.size(), n_fifo - f0);
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (act_grant[k] != order[k]) begin
          errors++;
          $display("FAIL rr_order[%0d]: got %0d need %0d",
                   k, act_grant[k], order[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int r0;
    int r1;
    r0 = n_ring;
    load_msg(2, 8, 8'hA0, 1);
    drive();
    wait_ring("bp", r0 + 3, 20);
    bus.send_ring_full = 1'b1;
    r1 = n_ring;
    for (int t = 0; t < 4; t++) tick();
    checks++;
    if (n_ring != r1) begin
      errors++;
      $display("FAIL bp_hold: %0d writes while full need 0", n_ring - r1);
    end
    bus.send_ring_full = 1'b0;
    drain("bp", 50);
    checks++;
    if (n_ring - r0 != 8) begin
      errors++;
      $display("FAIL bp_total: got %0d writes need 8", n_ring - r0);
    end
  endtask

  task automatic test_overflow();
    int r0 = n_ring;
    int o0 = n_ovf;
    int f0 = n_fifo;
    load_msg(3, 70, 8'h00, 1);
    drive();
    drain("ovf", 200);
    checks++;
    if (n_ring - r0 != MAXL || n_ovf - o0 != 1 || n_fifo - f0 != 1) begin
      errors++;
      $display("FAIL ovf_counts: ring=%0d ovf=%0d fifo=%0d need 63/1/1",
               n_ring - r0, n_ovf - o0, n_fifo - f0);
    end
  endtask

  task automatic test_fifo_full();
    int s0;
    bus.send_fifo_full = 1'b1;
    load_msg(1, 2, 8'h61, 1);
    load_msg(2, 2, 8'h71, 1);
    drive();
    for (int t = 0; t < 5; t++) begin
      tick();
      checks++;
      if (bus.grant !== '0) begin
        errors++;
        $display("FAIL ff_hold[%0d]: grant %b need 0", t, bus.grant);
      end
    end
    s0 = act_grant.size();
    bus.send_fifo_full = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.grant !== 4'b0010) begin
      errors++;
      $display("FAIL ff_release: grant %b need 0010", bus.grant);
    end
    drain("ff", 50);
    checks++;
    if (act_grant.size() != s0 + 2 || act_grant[s0] != 1
        || act_grant[s0+1] != 2) begin
      errors++;
      $display("FAIL ff_order: got %p need ...,1,2", act_grant);
    end
  endtask

  task automatic test_reset_mid();
    int r0 = n_ring;
    int f0;
    int s0;
    load_msg(2, 5, 8'h50, 1);
    drive();
    wait_ring("rmid", r0 + 2, 20);
    src_q[2].delete();
    exp_ring[2].delete();
    exp_len[2].delete();
    exp_ovf[2].delete();
    f0 = n_fifo;
    rst = 1'b1;
    drive();
    tick();
    rst = 1'b0;
    checks++;
    if (bus.grant !== '0 || bus.req_ready !== '0
        || bus.send_ring_wr_en !== 1'b0 || bus.send_fifo_wr_en !== 1'b0
        || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL rmid_outputs: g=%b rdy=%b rw=%b fw=%b ov=%b need 0",
               bus.grant, bus.req_ready, bus.send_ring_wr_en,
               bus.send_fifo_wr_en, bus.overflow);
    end
    tick();
    tick();
    checks++;
    if (n_fifo != f0) begin
      errors++;
      $display("FAIL rmid_nofifo: %0d fifo writes need 0", n_fifo - f0);
    end
    s0 = act_grant.size();
    load_msg(3, 2, 8'h90, 1);
    load_msg(0, 2, 8'h80, 1);
    drive();
    drain("rmid", 50);
    checks++;
    if (act_grant.size() < s0 + 1 || act_grant[s0] != 0) begin
      errors++;
      $display("FAIL rmid_winner: got %p need next=0", act_grant);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    n_ring = 0;
    n_fifo = 0;
    n_ovf  = 0;
    cur_g  = 0;
    fire   = '0;
    prev_grant = '0;
    rst = 1'b1;
    bus.req_valid      = '0;
    bus.req_data       = '0;
    bus.req_last       = '0;
    bus.send_ring_full = 1'b0;
    bus.send_fifo_full = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_fifo_full();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
